// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues one outstanding imem request at a time,
// buffers returned words with their PC in a 2-entry FIFO toward decode, and
// flushes/refetches on branch or jump redirects, discarding stale responses.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          BYTE_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [31:0] epc_q [2];
  logic [31:0] epc_d [2];

  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] rsp_word;

  // The memory image is big-endian, so words may need reversing before decode.
  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    swap_bytes = {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign rsp_word       = BYTE_SWAP ? swap_bytes(imem_rsp_data) : imem_rsp_data;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = (state_q == ST_FETCH) && (count_q < 2'd2) && !redirect_valid && !rst;
  assign out_valid      = (count_q != 2'd0) && !rst;
  assign out_instr      = instr_q[rd_ptr_q];
  assign out_pc         = epc_q[rd_ptr_q];

  // A redirect voids both the push of a response and any pop in the same cycle.
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop      = out_valid && out_ready && !redirect_valid;

  // Next-state logic for the request FSM, PC and FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = instr_q;
    epc_d    = epc_q;

    case (state_q)
      ST_FETCH: begin
        if (req_fire) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_FETCH;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end else begin
      pc_d = pc_q;
    end

    if (push) begin
      instr_d[wr_ptr_q] = rsp_word;
      epc_d[wr_ptr_q]   = req_pc_q;
      wr_ptr_d          = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Flush overrides everything: empty FIFO, realign pointers.
    if (redirect_valid) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d = count_d;
    end
  end

  // State registers with synchronous reset; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      instr_q[0] <= 32'd0;
      instr_q[1] <= 32'd0;
      epc_q[0]   <= 32'd0;
      epc_q[1]   <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q  <= instr_d;
      epc_q    <= epc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: the memory side is driven by hand, one
// cycle at a time, and every expected value is written out explicitly.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        req_valid, out_valid;
  logic [31:0] req_addr, out_instr, out_pc;
  logic        sw_req_valid, sw_out_valid;
  logic [31:0] sw_req_addr, sw_out_instr, sw_out_pc;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .BYTE_SWAP(1'b0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .BYTE_SWAP(1'b1)) dut_sw (
    .clk(clk), .rst(rst),
    .imem_req_valid(sw_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(sw_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(sw_out_valid), .out_ready(out_ready), .out_instr(sw_out_instr), .out_pc(sw_out_pc)
  );

  // 10 ns core clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a memory response for the next edge.
  task automatic rsp(input logic v, input logic [31:0] d);
    imem_rsp_valid = v;
    imem_rsp_data  = d;
    #1;
  endtask

  // Linear directed sequence.
  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);

    // ---- sequential fetch, 1-cycle memory, decode always ready
    rst = 1'b0; #1;
    chk("post_rst_req_valid", req_valid, 1'b1);
    chk("post_rst_addr", req_addr, 32'h0);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_out_instr", out_instr, 32'h0);
    chk("post_rst_out_pc", out_pc, 32'h0);
    imem_req_ready = 1'b1; out_ready = 1'b1; #1;
    tick();                                   // request 0x0 accepted
    chk("wait_no_req", req_valid, 1'b0);
    rsp(1'b1, 32'hA000_0000); tick(); rsp(1'b0, 32'h0);
    chk("seq0_valid", out_valid, 1'b1);
    chk("seq0_pc", out_pc, 32'h0);
    chk("seq0_instr", out_instr, 32'hA000_0000);
    chk("seq_addr4", req_addr, 32'h4);
    chk("seq_req4", req_valid, 1'b1);
    tick();                                   // pop 0x0, request 0x4
    chk("seq_empty", out_valid, 1'b0);
    rsp(1'b1, 32'hA000_0004); tick(); rsp(1'b0, 32'h0);
    chk("seq1_pc", out_pc, 32'h4);
    chk("seq_addr8", req_addr, 32'h8);
    tick();                                   // pop 0x4, request 0x8
    rsp(1'b1, 32'hA000_0008); tick(); rsp(1'b0, 32'h0);
    chk("seq2_pc", out_pc, 32'h8);
    chk("seq2_instr", out_instr, 32'hA000_0008);

    // ---- back-pressure
    rst = 1'b1; #1;
    chk("rst_gates_out_valid", out_valid, 1'b0);
    tick();
    rst = 1'b0; out_ready = 1'b0; #1;
    chk("bp_addr0", req_addr, 32'h0);
    tick();
    rsp(1'b1, 32'hA000_0000); tick(); rsp(1'b0, 32'h0);
    chk("bp_req4", req_valid, 1'b1);
    chk("bp_addr4", req_addr, 32'h4);
    tick();
    rsp(1'b1, 32'hA000_0004); tick(); rsp(1'b0, 32'h0);
    chk("bp_full_no_req", req_valid, 1'b0);
    chk("bp_head_pc", out_pc, 32'h0);
    tick(); tick();
    chk("bp_hold_no_req", req_valid, 1'b0);
    chk("bp_hold_pc", out_pc, 32'h0);
    chk("bp_hold_instr", out_instr, 32'hA000_0000);
    out_ready = 1'b1; #1;
    tick();                                   // pop 0x0 only
    chk("bp_drain_pc", out_pc, 32'h4);
    chk("bp_drain_instr", out_instr, 32'hA000_0004);
    chk("bp_resume_req", req_valid, 1'b1);
    chk("bp_resume_addr", req_addr, 32'h8);
    tick();                                   // pop 0x4, request 0x8
    chk("bp_drained", out_valid, 1'b0);
    rsp(1'b1, 32'hA000_0008); tick(); rsp(1'b0, 32'h0);
    chk("bp_next_pc", out_pc, 32'h8);
    tick();                                   // pop 0x8, request 0xC -> WAIT

    // ---- redirect while WAIT
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("redir_no_req", req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("drop_no_req", req_valid, 1'b0);
    chk("drop_empty", out_valid, 1'b0);
    rsp(1'b1, 32'hA000_000C); tick(); rsp(1'b0, 32'h0);
    chk("stale_dropped", out_valid, 1'b0);
    chk("redir_req", req_valid, 1'b1);
    chk("redir_addr", req_addr, 32'h100);
    tick();
    rsp(1'b1, 32'hA000_0100); tick(); rsp(1'b0, 32'h0);
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_instr", out_instr, 32'hA000_0100);

    // ---- redirect coincident with response and with a pop
    tick();                                   // request 0x104, entry 0x100 held
    rsp(1'b1, 32'hA000_0104);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; out_ready = 1'b1; #1;
    chk("coinc_no_req", req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0; rsp(1'b0, 32'h0);
    chk("coinc_flushed", out_valid, 1'b0);
    chk("coinc_req", req_valid, 1'b1);
    chk("coinc_addr", req_addr, 32'h200);
    tick();
    rsp(1'b1, 32'hA000_0200); tick(); rsp(1'b0, 32'h0);
    chk("coinc_out_valid", out_valid, 1'b1);
    chk("coinc_out_pc", out_pc, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; #1;
    chk("popredir_no_req", req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("popredir_flushed", out_valid, 1'b0);
    chk("popredir_addr", req_addr, 32'h300);

    // ---- byte swap
    tick();
    rsp(1'b1, 32'h1305_1000); tick(); rsp(1'b0, 32'h0);
    chk("noswap_pc", out_pc, 32'h300);
    chk("noswap_instr", out_instr, 32'h1305_1000);
    chk("swap_pc", sw_out_pc, 32'h300);
    chk("swap_instr", sw_out_instr, 32'h0010_0513);

    // ---- PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick();
    redirect_valid = 1'b0; #1;
    chk("wrap_flushed", out_valid, 1'b0);
    chk("wrap_req", req_valid, 1'b1);
    chk("wrap_addr_top", req_addr, 32'hFFFF_FFFC);
    tick();
    rsp(1'b1, 32'hA000_0001); tick(); rsp(1'b0, 32'h0);
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr_zero", req_addr, 32'h0);

    // ---- reset while WAIT with an entry buffered
    out_ready = 1'b0; #1;
    tick();                                   // request 0x0 outstanding
    chk("pre_rst_wait", req_valid, 1'b0);
    chk("pre_rst_buffered", out_valid, 1'b1);
    rst = 1'b1; #1;
    chk("rst_wait_out_valid", out_valid, 1'b0);
    chk("rst_wait_req_valid", req_valid, 1'b0);
    tick();
    rst = 1'b0; #1;
    chk("after_rst_out_valid", out_valid, 1'b0);
    chk("after_rst_req", req_valid, 1'b1);
    chk("after_rst_addr", req_addr, 32'h0);
    chk("after_rst_out_pc", out_pc, 32'h0);
    chk("after_rst_out_instr", out_instr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
